// File: rtl/cpu_ctrl_pkg.sv
// Shared front-panel controller types: mode encoding and step divider sizing.
// Also used by the core and lcd_top to display the current mode.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_FAST = 2'd2,
        MODE_EDIT = 2'd3
    } mode_t;

    localparam int DIV_W = 25;

    typedef logic [DIV_W-1:0] div_t;

    localparam int BTN_NEXT  = 0;
    localparam int BTN_RUN   = 1;
    localparam int BTN_SPEED = 2;
    localparam int BTN_SEND  = 3;
    localparam int BTN_EDIT  = 4;
    localparam int BTN_COUNT = 5;

    // Terminal divider count for the paced mode m.
    function automatic div_t div_last(input mode_t m, input int run_div, input int fast_div);
        return (m == MODE_FAST) ? div_t'(fast_div - 1) : div_t'(run_div - 1);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Front-panel bundle: raw buttons/switch and halt in, step/load pulses and mode out.
interface cpu_step_ctrl_if;

    logic       next;
    logic       run;
    logic       speedRun;
    logic       edit;
    logic       send;
    logic       halt;
    logic       step_en;
    logic       load_pulse;
    logic [1:0] mode;

    modport master (
        output next, run, speedRun, edit, send, halt,
        input  step_en, load_pulse, mode
    );

    modport slave (
        input  next, run, speedRun, edit, send, halt,
        output step_en, load_pulse, mode
    );

endinterface

// File: rtl/btn_debounce.sv
// 2-FF synchronizer plus hold-time debouncer; rise is a one-cycle pulse
// registered alongside the debounced level when it goes high.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            // Any return to the accepted level restarts the hold count.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_p1;
                rise  <= sync_p1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Front-panel execution controller: single-step, paced run (slow/fast) and
// program-edit mode, producing one-cycle step_en and load_pulse for the core.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 25_000_000,
    parameter int FAST_DIV        = 50_000
) (
    input  logic               clk,
    input  logic               rst,
    cpu_step_ctrl_if.slave     bus
);

    logic [BTN_COUNT-1:0] raw;
    logic [BTN_COUNT-1:0] lvl;
    logic [BTN_COUNT-1:0] rise;

    assign raw[BTN_NEXT]  = bus.next;
    assign raw[BTN_RUN]   = bus.run;
    assign raw[BTN_SPEED] = bus.speedRun;
    assign raw[BTN_SEND]  = bus.send;
    assign raw[BTN_EDIT]  = bus.edit;

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(lvl[i]),
            .rise (rise[i])
        );
    end

    // Buttons act on their rise only; the edit switch acts on its level only.
    logic unused_btn;
    assign unused_btn = &{1'b0, lvl[BTN_SEND:BTN_NEXT], rise[BTN_EDIT]};

    logic edit_lvl;
    logic next_rise;
    logic run_rise;
    logic speed_rise;
    logic send_rise;

    assign edit_lvl   = lvl[BTN_EDIT];
    assign next_rise  = rise[BTN_NEXT];
    assign run_rise   = rise[BTN_RUN];
    assign speed_rise = rise[BTN_SPEED];
    assign send_rise  = rise[BTN_SEND];

    mode_t state;
    div_t  div;
    logic  step_en;
    logic  load_pulse;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MODE_IDLE;
            div        <= '0;
            step_en    <= 1'b0;
            load_pulse <= 1'b0;
        end else begin
            step_en    <= 1'b0;
            load_pulse <= 1'b0;
            if (edit_lvl) begin
                state      <= MODE_EDIT;
                div        <= '0;
                load_pulse <= send_rise;
            end else begin
                unique case (state)
                    MODE_EDIT: begin
                        state <= MODE_IDLE;
                        div   <= '0;
                    end
                    MODE_IDLE: begin
                        div <= '0;
                        // A halted core may still be single-stepped, but not started.
                        if (bus.halt) begin
                            step_en <= next_rise;
                        end else if (speed_rise) begin
                            state <= MODE_FAST;
                        end else if (run_rise) begin
                            state <= MODE_RUN;
                        end else begin
                            step_en <= next_rise;
                        end
                    end
                    MODE_RUN, MODE_FAST: begin
                        if (bus.halt) begin
                            state <= MODE_IDLE;
                            div   <= '0;
                        end else if (speed_rise) begin
                            state <= (state == MODE_FAST) ? MODE_IDLE : MODE_FAST;
                            div   <= '0;
                        end else if (run_rise) begin
                            state <= (state == MODE_RUN) ? MODE_IDLE : MODE_RUN;
                            div   <= '0;
                        end else if (div == div_last(state, RUN_DIV, FAST_DIV)) begin
                            div     <= '0;
                            step_en <= 1'b1;
                        end else begin
                            div <= div + div_t'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.step_en    = step_en;
    assign bus.load_pulse = load_pulse;
    assign bus.mode       = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with short debounce and divider settings.
module tb_cpu_step_ctrl;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;
    int   step_cnt;
    int   load_cnt;
    logic prev_step;
    logic prev_load;

    cpu_step_ctrl_if bus();

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (10),
        .FAST_DIV       (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.step_en === 1'b1) step_cnt++;
            if (bus.load_pulse === 1'b1) load_cnt++;
            if (prev_step) check("step_width", int'(bus.step_en), 0);
            if (prev_load) check("load_width", int'(bus.load_pulse), 0);
            prev_step = (bus.step_en === 1'b1);
            prev_load = (bus.load_pulse === 1'b1);
        end
    endtask

    initial begin
        pass_cnt     = 0;
        fail_cnt     = 0;
        total_cnt    = 0;
        step_cnt     = 0;
        load_cnt     = 0;
        prev_step    = 1'b0;
        prev_load    = 1'b0;
        rst          = 1'b0;
        bus.next     = 1'b0;
        bus.run      = 1'b0;
        bus.speedRun = 1'b0;
        bus.edit     = 1'b0;
        bus.send     = 1'b0;
        bus.halt     = 1'b0;

        cyc(3);
        check("rst_step_en", int'(bus.step_en), 0);
        check("rst_load", int'(bus.load_pulse), 0);
        check("rst_mode", int'(bus.mode), 0);
        rst = 1'b1;
        cyc(2);

        // Bounce rejection on next
        step_cnt = 0;
        bus.next = 1'b1; cyc(1);
        bus.next = 1'b0; cyc(1);
        bus.next = 1'b1; cyc(1);
        bus.next = 1'b0; cyc(1);
        bus.next = 1'b1;
        cyc(6);
        check("bounce_no_early_step", step_cnt, 0);
        cyc(1);
        check("bounce_step_at_7", int'(bus.step_en), 1);
        cyc(9);
        bus.next = 1'b0;
        cyc(8);
        check("bounce_one_step", step_cnt, 1);
        check("bounce_mode_idle", int'(bus.mode), 0);

        // Slow run pacing
        bus.run = 1'b1;
        cyc(7);
        check("run_mode", int'(bus.mode), 1);
        bus.run  = 1'b0;
        step_cnt = 0;
        cyc(9);
        check("run_no_step_before_10", step_cnt, 0);
        cyc(1);
        check("run_step_10", int'(bus.step_en), 1);
        cyc(10);
        check("run_step_20", int'(bus.step_en), 1);
        cyc(10);
        check("run_step_30", int'(bus.step_en), 1);
        check("run_three_steps", step_cnt, 3);
        bus.run = 1'b1;
        cyc(7);
        check("run_toggle_idle", int'(bus.mode), 0);
        bus.run = 1'b0;
        cyc(20);
        check("run_stopped_steps", step_cnt, 3);

        // Fast run, switch to slow, then halt
        bus.speedRun = 1'b1;
        cyc(7);
        check("fast_mode", int'(bus.mode), 2);
        bus.speedRun = 1'b0;
        cyc(3);
        check("fast_step_3", int'(bus.step_en), 1);
        bus.run = 1'b1;
        cyc(7);
        check("fast_to_run_mode", int'(bus.mode), 1);
        bus.run  = 1'b0;
        step_cnt = 0;
        cyc(9);
        check("switch_div_restart", step_cnt, 0);
        cyc(1);
        check("switch_step_10", int'(bus.step_en), 1);
        cyc(9);
        bus.halt = 1'b1;
        cyc(1);
        check("halt_mode_idle", int'(bus.mode), 0);
        check("halt_step_suppressed", int'(bus.step_en), 0);
        bus.halt = 1'b0;
        cyc(15);
        check("halt_no_more_steps", step_cnt, 1);

        // Edit priority
        bus.run = 1'b1;
        cyc(7);
        check("edit_pre_run", int'(bus.mode), 1);
        bus.run = 1'b0;
        cyc(3);
        bus.edit = 1'b1;
        step_cnt = 0;
        cyc(7);
        check("edit_mode", int'(bus.mode), 3);
        check("edit_step_forced_0", step_cnt, 0);
        load_cnt = 0;
        bus.send = 1'b1;
        cyc(7);
        check("edit_load_1", int'(bus.load_pulse), 1);
        bus.send = 1'b0;
        cyc(7);
        bus.send = 1'b1;
        cyc(7);
        check("edit_load_2", int'(bus.load_pulse), 1);
        bus.send = 1'b0;
        cyc(7);
        check("edit_two_loads", load_cnt, 2);
        bus.next = 1'b1;
        cyc(10);
        bus.next = 1'b0;
        cyc(8);
        check("edit_next_ignored", step_cnt, 0);
        bus.edit = 1'b0;
        cyc(6);
        check("edit_still_edit", int'(bus.mode), 3);
        cyc(1);
        check("edit_exit_idle", int'(bus.mode), 0);

        // Send outside edit is ignored
        load_cnt = 0;
        bus.send = 1'b1;
        cyc(10);
        bus.send = 1'b0;
        cyc(8);
        check("send_idle_ignored", load_cnt, 0);

        // Simultaneous run and speedRun edges
        bus.run      = 1'b1;
        bus.speedRun = 1'b1;
        cyc(7);
        check("simul_fast_wins", int'(bus.mode), 2);
        bus.run      = 1'b0;
        bus.speedRun = 1'b0;
        cyc(8);

        // Asynchronous reset mid-run with run held through it
        bus.run = 1'b1;
        cyc(7);
        check("areset_pre_run", int'(bus.mode), 1);
        cyc(4);
        rst = 1'b0;
        #1;
        check("areset_mode", int'(bus.mode), 0);
        check("areset_step_en", int'(bus.step_en), 0);
        check("areset_load", int'(bus.load_pulse), 0);
        cyc(2);
        rst = 1'b1;
        cyc(6);
        check("areset_not_yet_run", int'(bus.mode), 0);
        cyc(1);
        check("areset_held_run_edge", int'(bus.mode), 1);
        bus.run = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Front-panel execution controller that sits directly upstream of the computer core. It debounces and edge-detects the board buttons (next, run, speedRun, send) and the edit switch. From these it produces a one-cycle `step_en` per instruction, either single-stepped or paced by a rate divider. It also produces a one-cycle `load_pulse` for committing a program word while in edit mode.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles an input must hold a new level before it is accepted (20 ms at 50 MHz).
- `RUN_DIV`, default 25_000_000: `step_en` period in RUN mode (2 Hz).
- `FAST_DIV`, default 50_000: `step_en` period in FAST mode (1 kHz).
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: asynchronous, active-low reset.
- `next` in 1: raw button, single step.
- `run` in 1: raw button, toggles slow run.
- `speedRun` in 1: raw button, toggles fast run.
- `edit` in 1: raw switch; high selects programming mode.
- `send` in 1: raw button, commits the current program word.
- `halt` in 1: synchronous level from the core; high means the program has halted.
- `step_en` out 1: one-cycle pulse; the core executes exactly one instruction per pulse.
- `load_pulse` out 1: one-cycle pulse; the ROM writes `code` at `unit`.
- `mode` out 2: current state encoding: 0 IDLE, 1 RUN, 2 FAST, 3 EDIT.

## Operation
- **Input conditioning.**
  - Each raw input passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce back to the old level resets the counter to 0.
  - Rising-edge detect on each debounced level yields an internal one-cycle event.
- **States:** IDLE, RUN, FAST, EDIT.
- **Priority for simultaneous events:** edit level > halt > speedRun edge > run edge > next edge.
- **EDIT.**
  - Entered from any state while debounced edit = 1.
  - The divider is cleared and `step_en` is forced to 0.
  - Each send edge produces `load_pulse`.
  - When debounced edit falls, the state goes to IDLE.
- **IDLE.**
  - A next edge produces exactly one `step_en`.
  - A run edge goes to RUN; a speedRun edge goes to FAST.
  - Send edges are ignored outside EDIT.
- **RUN and FAST.**
  - The divider counts 0..DIV-1, using `RUN_DIV` or `FAST_DIV` for the current mode.
  - At DIV-1 it emits `step_en` and wraps to 0.
  - Pressing the same button again returns to IDLE.
  - Pressing the other run button switches mode and clears the divider.
  - halt = 1 returns to IDLE and suppresses `step_en` in that cycle.
  - Next edges are ignored.
- **halt in IDLE:** next edges are still honoured. Single-stepping past a halt is the core's responsibility.
- **Divider:** 25-bit unsigned; cleared on every state change.

## Timing
- **Reset values:** `step_en` = 0, `load_pulse` = 0, `mode` = 0 (IDLE). Debounced levels = 0, divider = 0, debounce counters = 0.
- **Input latency:** a clean raw edge at cycle 0 is synchronized by cycle 2 and accepted as a debounced level at cycle 2+`DEBOUNCE_CYCLES`.
- **Output latency:** `step_en`, `load_pulse` and the `mode` change are registered and appear one cycle after the debounced edge.
- **Pacing:** on entering RUN or FAST at cycle t, the first `step_en` occurs at cycle t+DIV; later pulses come exactly every DIV cycles.
- **Pulse width:** `step_en` and `load_pulse` are never high for 2 consecutive cycles. At most one pulse is produced per debounced edge.
- **Held buttons:** a button held down produces no repeat events.
- **Mid-operation reset:** asserting `rst` at any time immediately returns all outputs to their reset values. After release, debounced levels start at 0. A button held through reset therefore produces one edge once it has been stable for `DEBOUNCE_CYCLES`.

## Structure
- **Shared package `cpu_ctrl_pkg`:** the 2-bit mode enum (IDLE, RUN, FAST, EDIT) and the divider width constant. The core and `lcd_top` use the same package to display the mode.
- **Sub-module `btn_debounce`**, parameterized by `DEBOUNCE_CYCLES`:
  - Contains the synchronizer, the counter, and the debounced level and rise outputs.
  - Instantiated five times.
- **Top FSM plus divider** live in `cpu_step_ctrl`. `halt` is not debounced.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RUN_DIV`=10, `FAST_DIV`=3.
- **Bounce rejection:** next toggles 1,0,1,0 each cycle, then holds 1 for 10 cycles → exactly one `step_en`, 7 cycles after the stable rise; `mode` stays 0.
- **Slow run:** press run → `mode`=1; `step_en` at +10, +20, +30 cycles. Press run again → `mode`=0 and no further pulses.
- **Mode switch and halt:**
  - FAST, then press run → `mode`=1 and the divider restarts; next pulse 10 cycles later.
  - Raise halt → `mode`=0 next cycle with no `step_en` that cycle.
- **Edit priority:** in RUN, set edit=1 → `mode`=3 and `step_en` stays 0. Press send twice → two `load_pulse`s. Press next → no `step_en`. Clear edit → `mode`=0.
- **Simultaneous events:** run and speedRun debounced edges in the same cycle from IDLE → `mode`=2.
- **Async reset:** pull `rst` low mid-RUN, between divider pulses → all outputs 0 immediately. Release with run still held → one run edge after 6 cycles, so `mode`=1.
